// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : datapath_pkg                                                     |
// | Brief   : Shared opcode, ALU command and reset constants for the datapath.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package datapath_pkg;

    localparam logic [1:0]  c_OP_DP  = 2'b00;
    localparam logic [1:0]  c_OP_MEM = 2'b01;
    localparam logic [1:0]  c_OP_BR  = 2'b10;

    localparam logic [3:0]  c_CMD_AND = 4'b0000;
    localparam logic [3:0]  c_CMD_SUB = 4'b0010;
    localparam logic [3:0]  c_CMD_ADD = 4'b0100;
    localparam logic [3:0]  c_CMD_ORR = 4'b1100;
    localparam logic [3:0]  c_CMD_MOV = 4'b1101;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    localparam int          c_NUM_REGS = 15;

endpackage
`default_nettype wire

// File: rtl/datapath_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : datapath_regfile                                                 |
// | Brief   : r0-r14 storage, combinational reads, one synchronous write port. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module datapath_regfile
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_raddr_a,
    input  logic [3:0]  i_raddr_b,
    input  logic [3:0]  i_raddr_c,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    output logic [31:0] o_rdata_c
);

    logic [31:0] w_regs [c_NUM_REGS];

    for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_reg
        logic [31:0] r_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (i_we && (i_waddr == 4'(i))) begin
                r_q <= i_wdata;
            end
        end
        assign w_regs[i] = r_q;
    end

    // Address 15 returns zero here; the parent substitutes PC+8.
    function automatic logic [31:0] f_read(input logic [3:0] addr);
        return (addr == 4'd15) ? 32'h0 : w_regs[addr];
    endfunction

    assign o_rdata_a = f_read(i_raddr_a);
    assign o_rdata_b = f_read(i_raddr_b);
    assign o_rdata_c = f_read(i_raddr_c);

endmodule
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : datapath                                                         |
// | Brief   : Single-cycle reduced ARMv4-style datapath (DP, LDR/STR, B).      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module datapath
    import datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] read_data,
    output logic [31:0] pc,
    output logic [31:0] addr_data,
    output logic [31:0] write_data,
    output logic        we
);

    logic [31:0] r_pc;

    logic [1:0]  w_op;
    logic        w_imm;
    logic [3:0]  w_cmd;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [3:0]  w_rm;
    logic        w_up;
    logic        w_load;
    logic        w_unused_cond;

    assign w_op          = instr[27:26];
    assign w_imm         = instr[25];
    assign w_cmd         = instr[24:21];
    assign w_up          = instr[23];
    assign w_load        = instr[20];
    assign w_rn          = instr[19:16];
    assign w_rd          = instr[15:12];
    assign w_rm          = instr[3:0];
    assign w_unused_cond = &instr[31:28];

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;

    logic [31:0] w_rf_rn;
    logic [31:0] w_rf_rd;
    logic [31:0] w_rf_rm;
    logic        w_reg_we;
    logic        w_wen;
    logic [31:0] w_wval;

    datapath_regfile u_regfile (
        .clk       (clk),
        .rst       (reset),
        .i_we      (w_reg_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_wval),
        .i_raddr_a (w_rn),
        .i_raddr_b (w_rd),
        .i_raddr_c (w_rm),
        .o_rdata_a (w_rf_rn),
        .o_rdata_b (w_rf_rd),
        .o_rdata_c (w_rf_rm)
    );

    logic [31:0] w_src1;
    logic [31:0] w_rd_val;
    logic [31:0] w_rm_val;
    logic [31:0] w_src2;

    assign w_src1   = (w_rn == 4'd15) ? w_pc_plus8 : w_rf_rn;
    assign w_rd_val = (w_rd == 4'd15) ? w_pc_plus8 : w_rf_rd;
    assign w_rm_val = (w_rm == 4'd15) ? w_pc_plus8 : w_rf_rm;
    assign w_src2   = w_imm ? {24'h0, instr[7:0]} : w_rm_val;

    logic [31:0] w_alu_result;
    logic        w_alu_valid;

    always_comb begin
        w_alu_result = '0;
        w_alu_valid  = 1'b0;
        case (w_cmd)
            c_CMD_ADD: begin w_alu_result = w_src1 + w_src2; w_alu_valid = 1'b1; end
            c_CMD_SUB: begin w_alu_result = w_src1 - w_src2; w_alu_valid = 1'b1; end
            c_CMD_AND: begin w_alu_result = w_src1 & w_src2; w_alu_valid = 1'b1; end
            c_CMD_ORR: begin w_alu_result = w_src1 | w_src2; w_alu_valid = 1'b1; end
            c_CMD_MOV: begin w_alu_result = w_src2;          w_alu_valid = 1'b1; end
            default:   begin w_alu_result = '0;              w_alu_valid = 1'b0; end
        endcase
    end

    logic [31:0] w_mem_offset;
    logic [31:0] w_mem_addr;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;

    assign w_mem_offset = {20'h0, instr[11:0]};
    assign w_mem_addr   = w_up ? (w_src1 + w_mem_offset) : (w_src1 - w_mem_offset);
    assign w_br_offset  = {{6{instr[23]}}, instr[23:0], 2'b00};
    assign w_br_target  = w_pc_plus8 + w_br_offset;

    logic [31:0] w_addr;
    logic        w_we_raw;
    logic [31:0] w_next_pc;

    always_comb begin
        w_addr    = '0;
        w_we_raw  = 1'b0;
        w_wen     = 1'b0;
        w_wval    = w_alu_result;
        w_next_pc = w_pc_plus4;
        case (w_op)
            c_OP_DP: begin
                w_addr = w_alu_result;
                w_wen  = w_alu_valid;
            end
            c_OP_MEM: begin
                w_addr   = w_mem_addr;
                w_we_raw = ~w_load;
                w_wen    = w_load;
                w_wval   = read_data;
            end
            c_OP_BR: begin
                w_addr    = w_br_target;
                w_next_pc = w_br_target;
            end
            default: begin
                w_addr = '0;
            end
        endcase
    end

    // r15 is never a write target; the PC only changes through w_next_pc.
    assign w_reg_we = w_wen & ~reset & (w_rd != 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign pc         = r_pc;
    assign addr_data  = w_addr;
    assign write_data = w_rd_val;
    assign we         = w_we_raw & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_datapath                                                      |
// | Brief   : Directed plus random checks of datapath against an ISA model.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] read_data;
    logic [31:0] pc;
    logic [31:0] addr_data;
    logic [31:0] write_data;
    logic        we;

    int checks   = 0;
    int failures = 0;

    datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .read_data  (read_data),
        .pc         (pc),
        .addr_data  (addr_data),
        .write_data (write_data),
        .we         (we)
    );

    always #5 clk = ~clk;

    // Architectural state of the reference model.
    logic [31:0] m_regs [15];
    logic [31:0] m_pc;
    logic        p_wen;
    logic [3:0]  p_widx;
    logic [31:0] p_wval;
    logic [31:0] p_npc;
    logic        p_rst;

    function automatic logic [31:0] m_read(input logic [3:0] idx);
        return (idx == 4'd15) ? m_pc + 32'd8 : m_regs[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
    endtask

    // Present one instruction, compare outputs with the model, stage its commit.
    task automatic drive(input logic [31:0] ins, input logic [31:0] rdata);
        logic [31:0] s1, s2, e_addr, off;
        logic        e_we, e_addr_ok, wen;
        @(negedge clk);
        reset     = 1'b0;
        instr     = ins;
        read_data = rdata;
        #1;
        s1 = m_read(ins[19:16]);
        e_addr = 32'h0; e_we = 1'b0; e_addr_ok = 1'b1; wen = 1'b0;
        p_wval = 32'h0; p_npc = m_pc + 32'd4;
        case (ins[27:26])
            2'd0: begin
                s2  = ins[25] ? {24'h0, ins[7:0]} : m_read(ins[3:0]);
                wen = 1'b1;
                case (ins[24:21])
                    4'd4:    e_addr = s1 + s2;
                    4'd2:    e_addr = s1 - s2;
                    4'd0:    e_addr = s1 & s2;
                    4'd12:   e_addr = s1 | s2;
                    4'd13:   e_addr = s2;
                    default: begin e_addr = 32'h0; wen = 1'b0; end
                endcase
                p_wval = e_addr;
            end
            2'd1: begin
                off    = {20'h0, ins[11:0]};
                e_addr = ins[23] ? s1 + off : s1 - off;
                e_we   = ~ins[20];
                wen    = ins[20];
                p_wval = rdata;
            end
            2'd2: begin
                e_addr = m_pc + 32'd8 + ({{8{ins[23]}}, ins[23:0]} * 32'd4);
                p_npc  = e_addr;
            end
            default: e_addr_ok = 1'b0;
        endcase
        p_wen  = wen && (ins[15:12] != 4'd15);
        p_widx = ins[15:12];
        p_rst  = 1'b0;
        chk("pc", pc, m_pc);
        chk("we", {31'h0, we}, {31'h0, e_we});
        chk("write_data", write_data, m_read(ins[15:12]));
        if (e_addr_ok) chk("addr_data", addr_data, e_addr);
    endtask

    task automatic rst_drive(input logic [31:0] ins);
        @(negedge clk);
        reset     = 1'b1;
        instr     = ins;
        read_data = $urandom;
        #1;
        p_rst = 1'b1;
        chk("rst_we", {31'h0, we}, 32'h0);
        chk("rst_pc", pc, m_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_rst) model_reset();
        else begin
            if (p_wen) m_regs[p_widx] = p_wval;
            m_pc = p_npc;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [3:0]  cmds [6];
        cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd13, 4'd0};
        ins = $urandom;
        if (ins[27:26] == 2'd0) begin
            cmds[5] = 4'($urandom);
            ins[24:21] = cmds[$urandom_range(0, 5)];
        end else if (ins[27:26] == 2'd1) begin
            ins[25] = 1'b0;
        end
        return ins;
    endfunction

    initial begin
        reset     = 1'b1;
        instr     = 32'h03A03002;
        read_data = 32'h0;
        p_wen = 1'b0; p_widx = 4'd0; p_wval = 32'h0; p_npc = 32'h0; p_rst = 1'b1;
        @(posedge clk);
        model_reset();

        // Reset held, then MOV r3,#2 repeatedly.
        repeat (4) begin
            rst_drive(32'h03A03002);
            chk("rst_pc_zero", pc, 32'h0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(32'h03A03002, 32'h0);
            chk("mov_pc", pc, 32'(4 * k));
            chk("mov_addr", addr_data, 32'd2);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(32'h02833001, 32'h0);
            chk("add_imm", addr_data, 32'(3 + k));
            tick();
        end
        drive(32'h02434001, 32'h0);
        chk("sub_imm", addr_data, 32'd6);
        tick();
        drive(32'h01A00004, 32'h0);
        chk("r4_after_sub", addr_data, 32'd6);
        tick();
        drive(32'h00833003, 32'h0);
        chk("r3_unchanged", write_data, 32'd7);
        chk("add_reg1", addr_data, 32'd14);
        tick();
        drive(32'h00833003, 32'h0);
        chk("add_reg2", addr_data, 32'd28);
        tick();
        drive(32'hE405B01A, 32'h1234_5678);
        chk("str_addr", addr_data, 32'hFFFF_FFE6);
        chk("str_we", {31'h0, we}, 32'd1);
        chk("str_wdata", write_data, 32'h0);
        tick();

        // Walk NOPs up to pc=0x20 and branch to self.
        rst_drive(32'hF000_0000);
        tick();
        repeat (8) begin drive(32'hF000_0000, 32'h0); tick(); end
        drive(32'hEAFFFFFE, 32'h0);
        chk("br_pc", pc, 32'h20);
        chk("br_target", addr_data, 32'h20);
        tick();
        drive(32'hEAFFFFFE, 32'h0);
        chk("br_self", pc, 32'h20);
        tick();
        rst_drive(32'hE405B01A);
        tick();
        drive(32'hF000_0000, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        tick();

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) rst_drive(rand_instr());
            else drive(rand_instr(), $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
